// File: rtl/alu_issue_arbiter.sv
// Two-requester issue arbiter in front of a shared combinational ALU.
// Round-robin grant on ties, one operation in flight, result held until consumed.
//
// state | meaning
// IDLE  | no operation in flight; grant offered to one valid requester
// EXEC  | operands applied to ALU; result and flags captured at end of cycle
// RESP  | result presented on rsp_*; waits for rsp_ready
module alu_issue_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_out,
  output logic [2:0]  flags,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic [3:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_id;
  logic        r_rsp_id;
  logic [15:0] r_rsp_data;
  logic [2:0]  r_flags;
  logic        r_rsp_valid;

  logic        w_idle;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [15:0] w_sum;
  logic [15:0] w_diff;
  logic        w_v_add;
  logic        w_v_sub;

  // rst_n gates the ready path so the handshake is dead while reset is held
  assign w_idle   = rst_n & (r_state == IDLE);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_grant0 = req0_valid & ~w_grant1;
  assign w_accept = w_idle & (req0_valid | req1_valid);

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  // Overflow is judged on the wrapped result, independent of any ALU saturation
  assign w_sum   = r_a + r_b;
  assign w_diff  = r_a - r_b;
  assign w_v_add = (r_a[15] == r_b[15]) & (w_sum[15] != r_a[15]);
  assign w_v_sub = (r_a[15] != r_b[15]) & (w_diff[15] != r_a[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= ~PRIO_INIT;
      r_op         <= 4'h0;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_id         <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= 16'h0000;
      r_flags      <= 3'b000;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op         <= w_grant1 ? req1_op : req0_op;
            r_a          <= w_grant1 ? req1_a  : req0_a;
            r_b          <= w_grant1 ? req1_b  : req0_b;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
          if (!r_op[3]) begin
            r_flags[2] <= (alu_out == 16'h0000);
          end
          if (r_op[3:1] == 3'b000) begin
            r_flags[1] <= r_op[0] ? w_v_sub : w_v_add;
            r_flags[0] <= alu_out[15];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign flags     = r_flags;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_arbiter;

  localparam logic PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  flags;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.PRIO_INIT(PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .flags(flags), .busy(busy)
  );

  // Shared ALU: saturating signed ADD/SUB, plain logic elsewhere
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int s;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? int'(signed'(a)) + int'(signed'(b)) : int'(signed'(a)) - int'(signed'(b));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
      end
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[3:0];
      4'd6: return a >> b[3:0];
      4'd7: return ~a;
      default: return a + b + {12'h000, op};
    endcase
  endfunction

  function automatic logic overflow(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int s;
    s = (op == 4'd0) ? int'(signed'(a)) + int'(signed'(b)) : int'(signed'(a)) - int'(signed'(b));
    return (s > 32767) || (s < -32768);
  endfunction

  assign alu_out = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: at most one transaction, aged by cycles since accept
  logic        m_active;
  int          m_age;
  logic        m_last;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b, m_data;
  logic        m_id, m_rid;
  logic [2:0]  m_flags;

  always @(negedge clk) begin
    logic g0, g1, z, v, n;
    logic [15:0] res;
    if (!rst_n) begin
      m_active = 1'b0; m_age = 0; m_last = ~PRIO;
      m_op = 4'h0; m_a = 16'h0; m_b = 16'h0; m_data = 16'h0;
      m_id = 1'b0; m_rid = 1'b0; m_flags = 3'b000;
    end
    if (req0_valid && req1_valid) begin
      g1 = ~m_last; g0 = m_last;
    end else begin
      g0 = req0_valid; g1 = req1_valid;
    end
    chk("busy",       32'(busy),       32'(m_active));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_active && m_age >= 2));
    chk("req0_ready", 32'(req0_ready), 32'(rst_n && !m_active && g0));
    chk("req1_ready", 32'(req1_ready), 32'(rst_n && !m_active && g1));
    chk("alu_op",     32'(alu_op),     32'(m_op));
    chk("alu_a",      32'(alu_a),      32'(m_a));
    chk("alu_b",      32'(alu_b),      32'(m_b));
    chk("rsp_data",   32'(rsp_data),   32'(m_data));
    chk("rsp_id",     32'(rsp_id),     32'(m_rid));
    chk("flags",      32'(flags),      32'(m_flags));
    if (rst_n) begin
      if (m_active) begin
        if (m_age == 1) begin
          res = alu_fn(m_op, m_a, m_b);
          z = m_flags[2]; v = m_flags[1]; n = m_flags[0];
          if (m_op < 4'd8) z = (res == 16'h0);
          if (m_op < 4'd2) begin
            v = overflow(m_op, m_a, m_b);
            n = res[15];
          end
          m_data = res; m_rid = m_id; m_flags = {z, v, n}; m_age = 2;
        end else if (rsp_ready) begin
          m_active = 1'b0;
        end
      end else if (g0 || g1) begin
        m_id   = g1;
        m_last = g1;
        m_op   = g1 ? req1_op : req0_op;
        m_a    = g1 ? req1_a  : req0_a;
        m_b    = g1 ? req1_b  : req0_b;
        m_active = 1'b1; m_age = 1;
      end
    end
  end

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; rsp_ready = 1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_n = 0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic run_op(input string nm, input bit id, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_d, input logic [2:0] exp_f);
    int n;
    @(posedge clk); #1;
    rsp_ready = 1;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 20) begin n++; @(negedge clk); end
    chk({nm, "_accept_timeout"}, 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin n++; @(negedge clk); end
    chk({nm, "_latency"}, 32'(n), 32'd2);
    chk({nm, "_data"},    32'(rsp_data), 32'(exp_d));
    chk({nm, "_id"},      32'(rsp_id),   32'(id));
    chk({nm, "_flags"},   32'(flags),    32'(exp_f));
    @(posedge clk); #1;
  endtask

  initial begin
    int n, k, hold_d;
    int t_acc[4];
    int id_acc[4];
    rst_n = 0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_n = 1;

    run_op("add_small",  1'b0, 4'd0, 16'h0003, 16'h0004, 16'h0007, 3'b000);
    run_op("add_ovf",    1'b1, 4'd0, 16'h7000, 16'h7000, 16'h7FFF, 3'b010);
    run_op("xor_keep_v", 1'b0, 4'd4, 16'h00FF, 16'h00F0, 16'h000F, 3'b010);
    run_op("sub_zero",   1'b1, 4'd1, 16'h0005, 16'h0005, 16'h0000, 3'b100);
    run_op("op8_retain", 1'b0, 4'd8, 16'h0000, 16'h0000, 16'h0008, 3'b100);
    run_op("xor",        1'b0, 4'd4, 16'h00FF, 16'h00F0, 16'h000F, 3'b000);
    run_op("sub_neg",    1'b1, 4'd1, 16'h0001, 16'h0003, 16'hFFFE, 3'b001);

    // Round robin under continuous contention
    do_reset(2);
    req0_valid = 1; req1_valid = 1; req0_op = 4'd2; req1_op = 4'd3;
    req0_a = 16'h1234; req0_b = 16'h00FF; req1_a = 16'h0F00; req1_b = 16'h0011;
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        t_acc[k] = n; id_acc[k] = req1_ready ? 1 : 0; k++;
      end
      n++;
    end
    chk("rr_count", 32'(k), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_id", 32'(id_acc[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(t_acc[i] - t_acc[i-1]), 32'd3);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure held in RESP
    rsp_ready = 0;
    req0_valid = 1; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0002;
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin n++; @(negedge clk); end
    chk("bp_accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin n++; @(negedge clk); end
    chk("bp_rsp_timeout", 32'(n < 20), 32'd1);
    hold_d = 32'(rsp_data);
    chk("bp_data", 32'(hold_d), 32'h0003);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data_held", 32'(rsp_data), 32'(hold_d));
      chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1; req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted during EXEC
    req1_valid = 1; req1_op = 4'd0; req1_a = 16'h000A; req1_b = 16'h0014;
    n = 0;
    @(negedge clk);
    while (!req1_ready && n < 20) begin n++; @(negedge clk); end
    chk("rx_accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    chk("rx_in_exec", 32'(busy), 32'd1);
    req0_valid = 1;
    #1 rst_n = 0;
    #1;
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rx_rsp_data", 32'(rsp_data), 32'd0);
    chk("rx_rsp_id", 32'(rsp_id), 32'd0);
    chk("rx_alu", 32'({alu_op, alu_a, alu_b[11:0]}), 32'd0);
    chk("rx_alu_b", 32'(alu_b), 32'd0);
    chk("rx_flags", 32'(flags), 32'd0);
    chk("rx_ready", 32'({req0_ready, req1_ready}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 0; req1_valid = 0;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rx_no_stale", 32'({rsp_valid, busy}), 32'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rx_first_tie", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      #1;
      if (c == 1200) rst_n = 0;
      if (c == 1202) rst_n = 1;
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_op = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      req1_op = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      req0_a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      req0_b = ($urandom_range(0, 3) == 0) ? req0_a : 16'($urandom);
      req1_a = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      req1_b = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      @(posedge clk);
    end
    #1;
    clear_inputs();
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 SHALL have parameter PRIO_INIT, default 0: requester that wins the first simultaneous request after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation accepted this cycle when valid&ready.
REQ-006 SHALL have ports req0_op / req1_op  input  4  ALU opcode.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16  operands.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result when valid&ready.
REQ-010 SHALL have port rsp_id  output  1  requester index owning the result.
REQ-011 SHALL have port rsp_data  output  16  ALU result.
REQ-012 SHALL have port alu_op  output  4  opcode to shared ALU.
REQ-013 SHALL have ports alu_a / alu_b  output  16  operands to shared ALU.
REQ-014 SHALL have port alu_out  input  16  combinational ALU result.
REQ-015 SHALL have port flags  output  3  {Z,V,N} = flags[2:0].
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-018 IDLE: req_ready high only for granted requester, only in IDLE; both low otherwise.
REQ-019 Grant: single valid requester wins; both valid -> requester not granted last wins (round-robin); last_grant updates only on accept.
REQ-020 On accept, op/a/b/id registered, IDLE -> EXEC.
REQ-021 alu_op/alu_a/alu_b SHALL be driven from operand registers at all times.
REQ-022 EXEC (exactly one cycle): alu_out captured into rsp_data, flags updated, EXEC -> RESP.
REQ-023 RESP: rsp_valid high; rsp_data, rsp_id stable until rsp_ready; on handshake RESP -> IDLE, rsp_valid low next cycle.
REQ-024 Latency: accept in cycle N -> rsp_valid in cycle N+2; minimum 3 cycles per operation; new accept no earlier than cycle after response handshake.
REQ-025 Z SHALL update for opcodes 0000-0111: Z = (alu_out == 0).
REQ-026 N, V SHALL update only for opcodes 0000 (ADD) and 0001 (SUB): N = alu_out[15]; V = signed overflow of a+b or a-b computed on unsaturated 16-bit two's-complement.
REQ-027 Opcodes 1xxx SHALL execute normally with all flags retained.
REQ-028 Requester dropping valid while not granted SHALL be legal; no accept recorded.
REQ-029 Backpressure on rsp_ready SHALL stall indefinitely without loss or corruption.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0, alu_op/alu_a/alu_b 0, flags 000, busy 0, req_ready 0.
REQ-031 last_grant SHALL reset to ~PRIO_INIT so PRIO_INIT wins first tie.
REQ-032 Reset during EXEC or RESP SHALL discard the transaction; no response issued after release.

Verification
REQ-033 req0 ADD a=0x0003 b=0x0004 -> rsp_valid at accept+2, rsp_data 0x0007, rsp_id 0, flags 000.
REQ-034 req1 ADD a=0x7000 b=0x7000 -> rsp_data 0x7FFF, rsp_id 1, V=1, N=0, Z=0.
REQ-035 PRIO_INIT=0, both valid continuously, rsp_ready=1 -> grants 0,1,0,1, one accept every 3 cycles.
REQ-036 SUB 0x0005-0x0005 -> 0x0000, Z=1; then XOR 0x00FF,0x00F0 -> 0x000F, Z=0, V/N unchanged.
REQ-037 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data held, both req_ready low, no accept.
REQ-038 rst_n asserted during EXEC -> all outputs 0 asynchronously; after release, first tie granted to requester 0, no stale response.
